// File: rtl/clock_rate_detector_pkg.sv
// clock_rate_detector_pkg: shared rate codes, default timing and FSM encoding for the blink-clock rate detector
package clock_rate_detector_pkg;
  localparam logic [1:0] RATE_1HZ = 2'd0;
  localparam logic [1:0] RATE_2HZ = 2'd1;
  localparam logic [1:0] RATE_4HZ = 2'd2;
  localparam logic [1:0] RATE_8HZ = 2'd3;
  localparam int unsigned HALF_1HZ_DEF = 25_000_000;
  typedef enum logic {SYNC = 1'b0, MEAS = 1'b1} state_t;
endpackage

// File: rtl/clock_rate_detector_sync_edge_detect.sv
// sync_edge_detect: 2-FF synchroniser plus toggle detect for a slow asynchronous level
//   clk_50   in  sampling clock
//   rstn     in  synchronous active-low reset
//   async_in in  asynchronous input level
//   level    out synchronised level
//   toggle   out one-cycle pulse on either polarity of level change
module sync_edge_detect (
  input  logic clk_50,
  input  logic rstn,
  input  logic async_in,
  output logic level,
  output logic toggle
);
  logic s1, s2, s3;
  always_ff @(posedge clk_50) begin
    if (!rstn) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {async_in, s1, s2};
  end
  assign level  = s2;
  assign toggle = s2 ^ s3;
endmodule

// File: rtl/clock_rate_detector.sv
// clock_rate_detector: times half periods of a slow square wave and classifies them as 1/2/4/8 Hz
//   clk_50     in  50 MHz system clock
//   rstn       in  synchronous active-low reset
//   sig_in     in  asynchronous square wave under test
//   period     out last measured half period in clk_50 cycles
//   rate       out last matched rate code (0=1 Hz .. 3=8 Hz)
//   rate_valid out last measured period matched a code
//   upd        out one-cycle pulse when period/rate/rate_valid refresh
//   lost       out no edge seen for TIMEOUT cycles
module clock_rate_detector
  import clock_rate_detector_pkg::*;
#(
  parameter int CNT_W             = 27,
  parameter int unsigned HALF_1HZ = HALF_1HZ_DEF,
  parameter int unsigned TOL      = 65_536,
  parameter int unsigned TIMEOUT  = 50_000_000
) (
  input  logic             clk_50,
  input  logic             rstn,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       rate,
  output logic             rate_valid,
  output logic             upd,
  output logic             lost
);
  if (TOL >= HALF_1HZ / 16) begin : g_bad_tol
    $error("TOL must be below HALF_1HZ/16 so the rate windows stay disjoint");
  end
  if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT must fit in CNT_W bits");
  end
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W:0]   HALF_W  = (CNT_W + 1)'(HALF_1HZ);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   p, nom, lo, hi;
  logic [1:0]       code;
  logic             hit, sig_edge;
  sync_edge_detect u_sync (
    .clk_50  (clk_50),
    .rstn    (rstn),
    .async_in(sig_in),
    .level   (),
    .toggle  (sig_edge)
  );
  // Windows are disjoint, so at most one k can hit; the lower bound clamps at zero.
  always_comb begin
    p    = {1'b0, cnt} + (CNT_W + 1)'(1);
    hit  = 1'b0;
    code = rate;
    nom  = '0;
    lo   = '0;
    hi   = '0;
    for (int k = 0; k < 4; k++) begin
      nom = HALF_W >> k;
      lo  = (nom > TOL_W) ? nom - TOL_W : '0;
      hi  = nom + TOL_W;
      if (p >= lo && p <= hi) begin
        hit  = 1'b1;
        code = 2'(k);
      end
    end
  end
  // An edge on the timeout cycle is measured, so the edge branch is tested first.
  always_ff @(posedge clk_50) begin
    if (!rstn) begin
      cnt        <= '0;
      period     <= '0;
      rate       <= RATE_1HZ;
      rate_valid <= 1'b0;
      upd        <= 1'b0;
      lost       <= 1'b0;
      state      <= SYNC;
    end else begin
      upd <= 1'b0;
      cnt <= sig_edge ? '0 : (cnt == CNT_MAX ? cnt : cnt + CNT_W'(1));
      if (state == SYNC) begin
        if (sig_edge) begin
          lost  <= 1'b0;
          state <= MEAS;
        end
      end else if (sig_edge) begin
        period     <= p[CNT_W-1:0];
        upd        <= 1'b1;
        rate_valid <= hit;
        if (hit) rate <= code;
      end else if (cnt == CNT_MAX) begin
        lost       <= 1'b1;
        rate_valid <= 1'b0;
        cnt        <= '0;
        state      <= SYNC;
      end
    end
  end
endmodule

// File: tb/tb_clock_rate_detector.sv
// tb_clock_rate_detector: randomized self-checking bench for clock_rate_detector against an edge-time model
module tb_clock_rate_detector;
  localparam int HALF = 1600;
  localparam int TOLR = 16;
  localparam int TOUT = 4000;
  logic        clk_50 = 1'b0;
  logic        rstn   = 1'b0;
  logic        sig_in = 1'b0;
  logic [26:0] period;
  logic [1:0]  rate;
  logic        rate_valid, upd, lost;
  int vec = 0;
  int err = 0;
  clock_rate_detector #(
    .CNT_W(27), .HALF_1HZ(HALF), .TOL(TOLR), .TIMEOUT(TOUT)
  ) dut (
    .clk_50    (clk_50),
    .rstn      (rstn),
    .sig_in    (sig_in),
    .period    (period),
    .rate      (rate),
    .rate_valid(rate_valid),
    .upd       (upd),
    .lost      (lost)
  );
  always #10 clk_50 = ~clk_50;
  // Reference model: the detector sees sig_in two samples late (zero-filled by reset);
  // a half period is the distance in clock edges between consecutive seen changes.
  int          t = 0, t_last = 0, p_m = 0;
  bit          armed = 1'b0, det;
  logic [2:0]  h = 3'b000;
  logic [26:0] m_period = '0;
  logic [1:0]  m_rate = '0;
  logic        m_valid = 1'b0, m_upd = 1'b0, m_lost = 1'b0;
  always @(posedge clk_50) begin
    t++;
    if (!rstn) begin
      h = 3'b000; armed = 1'b0;
      m_period = '0; m_rate = '0; m_valid = 1'b0; m_upd = 1'b0; m_lost = 1'b0;
    end else begin
      det   = h[1] ^ h[2];
      m_upd = 1'b0;
      if (det && armed) begin
        p_m = t - t_last; m_period = 27'(p_m); m_upd = 1'b1; m_valid = 1'b0;
        for (int k = 0; k < 4; k++)
          if (p_m >= (HALF >> k) - TOLR && p_m <= (HALF >> k) + TOLR) begin
            m_valid = 1'b1; m_rate = 2'(k);
          end
        t_last = t;
      end else if (det) begin
        armed = 1'b1; m_lost = 1'b0; t_last = t;
      end else if (armed && t - t_last == TOUT) begin
        m_lost = 1'b1; m_valid = 1'b0; armed = 1'b0;
      end
      h = {h[1:0], sig_in};
    end
  end
  logic [31:0] obs, exp_all;
  assign obs     = {period, rate, rate_valid, upd, lost};
  assign exp_all = {m_period, m_rate, m_valid, m_upd, m_lost};
  int bad_cyc, upd_cnt, upd_lat;
  logic [31:0] bad_obs, bad_exp;
  // Optionally toggles sig_in, then runs n cycles, tallying model disagreement and upd activity.
  task automatic drive_half(input int n, input bit flip);
    if (flip) sig_in = ~sig_in;
    upd_lat = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_50);
      if (obs !== exp_all) begin
        if (bad_cyc == 0) begin bad_obs = obs; bad_exp = exp_all; end
        bad_cyc++;
      end
      if (upd === 1'b1) begin
        upd_cnt++;
        if (upd_lat == 0) upd_lat = i + 1;
      end
    end
  endtask
  task automatic clear_stats();
    bad_cyc = 0; upd_cnt = 0; bad_obs = '0; bad_exp = '0;
  endtask
  task automatic test_reset();
    clear_stats();
    rstn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = ~sig_in;
      @(negedge clk_50);
      vec++;
      if (obs !== 32'd0) begin err++; $display("FAIL reset_hold cyc %0d: got %h want 0", i, obs); end
    end
    sig_in = 1'b1; rstn = 1'b1;
    drive_half(8, 1'b0);
    vec++;
    if (upd_cnt !== 0 || lost !== 1'b0) begin
      err++; $display("FAIL reset_first_edge: upd_cnt=%0d lost=%0b want 0/0", upd_cnt, lost);
    end
    vec++;
    if (bad_cyc !== 0) begin err++; $display("FAIL reset_trace: %0d cycles, got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask
  task automatic test_2hz();
    clear_stats();
    for (int i = 0; i < 6; i++) drive_half(800, 1'b1);
    vec++;
    if ({period, rate, rate_valid} !== {27'd800, 2'd1, 1'b1}) begin
      err++; $display("FAIL 2hz_result: got p=%0d r=%0d v=%0b want 800/1/1", period, rate, rate_valid);
    end
    vec++;
    if (upd_lat !== 3 || upd_cnt !== 6) begin
      err++; $display("FAIL 2hz_upd: got lat=%0d cnt=%0d want 3/6", upd_lat, upd_cnt);
    end
    vec++;
    if (bad_cyc !== 0) begin err++; $display("FAIL 2hz_trace: %0d cycles, got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask
  task automatic test_boundary();
    clear_stats();
    drive_half(215, 1'b1);
    drive_half(217, 1'b1);
    vec++;
    if ({period, rate, rate_valid} !== {27'd215, 2'd3, 1'b1}) begin
      err++; $display("FAIL boundary_215: got p=%0d r=%0d v=%0b want 215/3/1", period, rate, rate_valid);
    end
    drive_half(10, 1'b1);
    vec++;
    if ({period, rate, rate_valid} !== {27'd217, 2'd3, 1'b0}) begin
      err++; $display("FAIL boundary_217: got p=%0d r=%0d v=%0b want 217/3/0", period, rate, rate_valid);
    end
    vec++;
    if (bad_cyc !== 0) begin err++; $display("FAIL boundary_trace: %0d cycles, got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask
  task automatic test_lost();
    clear_stats();
    drive_half(4000, 1'b0);
    vec++;
    if ({lost, rate_valid} !== 2'b10 || upd_cnt !== 0) begin
      err++; $display("FAIL lost_set: got lost=%0b v=%0b upd_cnt=%0d want 1/0/0", lost, rate_valid, upd_cnt);
    end
    drive_half(1600, 1'b1);
    vec++;
    if (lost !== 1'b0 || upd_cnt !== 0) begin
      err++; $display("FAIL lost_rearm: got lost=%0b upd_cnt=%0d want 0/0", lost, upd_cnt);
    end
    drive_half(5, 1'b1);
    vec++;
    if ({period, rate, rate_valid, upd_cnt} !== {27'd1600, 2'd0, 1'b1, 32'd1}) begin
      err++; $display("FAIL lost_recover: got p=%0d r=%0d v=%0b upd_cnt=%0d want 1600/0/1/1", period, rate, rate_valid, upd_cnt);
    end
    vec++;
    if (bad_cyc !== 0) begin err++; $display("FAIL lost_trace: %0d cycles, got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask
  task automatic test_timeout_edge();
    clear_stats();
    drive_half(4000, 1'b1);
    upd_cnt = 0;
    drive_half(8, 1'b1);
    vec++;
    if ({lost, period, rate_valid, upd_cnt} !== {1'b0, 27'd4000, 1'b0, 32'd1}) begin
      err++; $display("FAIL timeout_edge: got lost=%0b p=%0d v=%0b upd_cnt=%0d want 0/4000/0/1", lost, period, rate_valid, upd_cnt);
    end
    vec++;
    if (bad_cyc !== 0) begin err++; $display("FAIL timeout_trace: %0d cycles, got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask
  task automatic test_reset_mid();
    clear_stats();
    if (sig_in) drive_half(800, 1'b1);
    drive_half(800, 1'b1);
    drive_half(800, 1'b1);
    drive_half(400, 1'b0);
    rstn = 1'b0;
    @(negedge clk_50);
    vec++;
    if (obs !== 32'd0) begin err++; $display("FAIL reset_mid_zero: got %h want 0", obs); end
    rstn = 1'b1;
    upd_cnt = 0;
    drive_half(400, 1'b0);
    drive_half(800, 1'b1);
    vec++;
    if (upd_cnt !== 0) begin err++; $display("FAIL reset_mid_arm: got upd_cnt=%0d want 0", upd_cnt); end
    drive_half(800, 1'b1);
    vec++;
    if ({period, rate, rate_valid, upd_cnt} !== {27'd800, 2'd1, 1'b1, 32'd1}) begin
      err++; $display("FAIL reset_mid_meas: got p=%0d r=%0d v=%0b upd_cnt=%0d want 800/1/1/1", period, rate, rate_valid, upd_cnt);
    end
    vec++;
    if (bad_cyc !== 0) begin err++; $display("FAIL reset_mid_trace: %0d cycles, got %h want %h", bad_cyc, bad_obs, bad_exp); end
  endtask
  task automatic test_random();
    int n, k;
    for (int i = 0; i < 24; i++) begin
      clear_stats();
      k = int'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       n = (HALF >> k) + int'($urandom_range(0, 40)) - 20;
        1:       n = int'($urandom_range(30, 1700));
        default: n = (HALF >> k) + ($urandom_range(0, 1) ? 1 : -1) * (TOLR + int'($urandom_range(0, 1)));
      endcase
      drive_half(n, 1'b1);
      vec++;
      if (bad_cyc !== 0) begin
        err++; $display("FAIL random_%0d n=%0d: %0d cycles, got %h want %h", i, n, bad_cyc, bad_obs, bad_exp);
      end
    end
  endtask
  initial begin
    test_reset();
    test_2hz();
    test_boundary();
    test_lost();
    test_timeout_edge();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
